// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, datapath widths and default bit timing.
package uart_pkg;
    localparam int UART_DATA_W       = 8;
    localparam int UART_CNT_W        = 12;
    localparam int UART_CLKS_PER_BIT = 87;  // 10 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte channel between the UART receiver and its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] data;
    logic                   valid;
    logic                   ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous pins; resets to 1 (idle line) and holds when ce is low.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else if (ce) begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// UART byte receiver, 8N1 by default; define UART_RX_PARITY_EN to expect an even parity bit.
// Good bytes go out through a one-entry valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ce,
    input  logic      rx,
    uart_rx_if.master bus,
    output logic      frame_err,
    output logic      parity_err,
    output logic      overrun,
    output logic      busy
);
    localparam logic [UART_CNT_W-1:0] CNT_HALF = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [UART_CNT_W-1:0] CNT_FULL = UART_CNT_W'(CLKS_PER_BIT - 1);

    uart_rx_state_t         state_q, state_d;
    logic [UART_CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]             bitidx_q, bitidx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   rx_s;
    logic                   tick;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   perr_q, perr_d;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? cnt_q : cnt_q - 1'b1;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q && !bus.ready;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                // Line back high at mid start bit: a glitch, drop it silently.
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        cnt_d    = CNT_FULL;
                        bitidx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d  = {rx_s, shreg_q[UART_DATA_W-1:1]};
                    cnt_d    = CNT_FULL;
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bad_d = rx_s ^ (^shreg_q);
                    cnt_d     = CNT_FULL;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving mid stop bit lets a back-to-back start edge be caught.
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) perr_d = 1'b1; else
`endif
                        if (!valid_q || bus.ready) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else if (ce) begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);
endmodule
